// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// One M-extension op per start pulse. A shared 32-iteration datapath does
// shift-add multiplication or restoring division on operand magnitudes.
// Sign fix-up and the special cases are handled in the FIX state.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, divide-by-zero,
// signed overflow and multiply-by-zero skip CALC and go straight to FIX.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_a;        // |op_a|: multiplicand, or dividend shifted out MSB-first
    logic [XLEN-1:0]   r_b;        // |op_b|: multiplier shifted out LSB-first, or divisor
    logic [XLEN-1:0]   r_a_raw;    // op_a as issued, needed for the REM-by-zero result
    logic              r_neg_q;    // negate product / quotient
    logic              r_neg_r;    // negate remainder
    logic              r_div0;
    logic              r_ovf;
    logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient}
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // Issue-time operand decode (only meaningful in IDLE)
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0_in;
    logic              w_ovf_in;
    logic              w_early;

    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sign_a   = w_a_signed & op_a[XLEN-1];
    assign w_sign_b   = w_b_signed & op_b[XLEN-1];
    assign w_abs_a    = w_sign_a ? -op_a : op_a;
    assign w_abs_b    = w_sign_b ? -op_b : op_b;
    assign w_div0_in  = (op_b == '0);
    assign w_ovf_in   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = w_div0_in | w_ovf_in | (~funct3[2] & (op_a == '0));
`else
    assign w_early = 1'b0;
`endif

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the 64-bit product right by one.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_b[0] ? r_a : {XLEN{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: shift {rem, dividend} left by one and trial-subtract the
    // divisor. The shifted remainder is one bit wider than XLEN, so the compare
    // is done at XLEN+1 bits; the difference itself always fits in XLEN bits.
    logic [XLEN:0]     w_rem_sh;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_sub;
    logic [XLEN-1:0]   w_rem_next;
    logic [2*XLEN-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_b});
    assign w_sub      = w_rem_sh[XLEN-1:0] - r_b;
    assign w_rem_next = w_q_bit ? w_sub : w_rem_sh[XLEN-1:0];
    assign w_div_next = {w_rem_next, r_acc[XLEN-2:0], w_q_bit};

    // Sign fix-up and result selection, including the special-case overrides
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched op
    always_comb begin
        w_fix_result = '0;
        case (r_f3)
            3'b000:                   w_fix_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:   w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100: begin
                if (r_div0)           w_fix_result = '1;
                else if (r_ovf)       w_fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else                  w_fix_result = w_quo;
            end
            3'b101:                   w_fix_result = r_div0 ? '1 : w_quo;
            3'b110: begin
                if (r_div0)           w_fix_result = r_a_raw;
                else if (r_ovf)       w_fix_result = '0;
                else                  w_fix_result = w_rem;
            end
            3'b111:                   w_fix_result = r_div0 ? r_a_raw : w_rem;
            default:                  w_fix_result = '0;
        endcase
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            // Abort: back to IDLE, no done, result left untouched
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f3    <= funct3;
                        r_a     <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_a_raw <= op_a;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        r_div0  <= w_div0_in;
                        r_ovf   <= w_ovf_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= w_early ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_f3[2]) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed RV32M cases, corner cases, flush/reset
// behaviour and random operations, checked through a result scoreboard.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_exp[$];
    int          q_edge[$];
    logic [31:0] last_res = 32'h0;

    muldiv_seq #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference RV32M semantics, computed with 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = 64'h0;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Index of the clock edge (counting the start-sampling edge as 0) after
    // which done is visible: 33 normally, 1 for an early-out op.
    function automatic int ref_done_edge(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 32'h0) return 1;
        if (((f3 == 3'b100) || (f3 == 3'b110)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        if (!f3[2] && a == 32'h0) return 1;
`endif
        return 33;
    endfunction

    task automatic wait_done(output logic seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic pop_and_check(input logic seen, input int cyc, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_res;
        int          e_edge;
        e_res  = q_exp.pop_front();
        e_edge = q_edge.pop_front();
        check_val("done_seen", 64'(seen), 64'd1);
        check_val("done_edge", 64'(cyc), 64'(e_edge));
        check_val("result", 64'(result), 64'(e_res));
        $display("op f3=%0d a=%h b=%h result=%h expect=%h done_edge=%0d", f3, a, b, result, e_res, cyc);
        last_res = e_res;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        logic seen;
        int   cyc;
        q_exp.push_back(exp);
        q_edge.push_back(ref_done_edge(f3, a, b));
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val("busy_after_start", 64'(busy), 64'd1);
        wait_done(seen, cyc);
        pop_and_check(seen, cyc, f3, a, b);
        @(posedge clk);
        #1;
        check_val("done_one_cycle", 64'(done), 64'd0);
        check_val("busy_after_done", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        seen;
        int          cyc;
        int          extra_done;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        vecs.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        vecs.push_back('{3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006});
        vecs.push_back('{3'b010, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA});
        vecs.push_back('{3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE});
        vecs.push_back('{3'b101, 32'd20, 32'd3, 32'd6});
        vecs.push_back('{3'b111, 32'd20, 32'd3, 32'd2});
        vecs.push_back('{3'b100, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0});
        vecs.push_back('{3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'b000, 32'd0, 32'h0001_2345, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001});
        vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE});
        foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Random ops against the reference model
        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'h0;
            if (i % 4 == 2) ra = 32'h0;
            if (i % 8 == 7) rb = 32'($urandom_range(1, 15));
            run_op(rf, ra, rb, ref_result(rf, ra, rb));
        end

        // Flush during a DIV: abort, no done, result holds; then a new op
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_done", 64'(done), 64'd0);
        check_val("flush_result_hold", 64'(result), 64'(last_res));
        @(posedge clk);
        #1;
        check_val("flush_no_done", 64'(done), 64'd0);
        run_op(3'b100, 32'd1000, 32'd7, 32'd142);

        // Reset mid-CALC clears outputs immediately
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset_busy", 64'(busy), 64'd0);
        check_val("midreset_done", 64'(done), 64'd0);
        check_val("midreset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 32'h0;

        // start while busy is ignored: exactly one done
        q_exp.push_back(32'd56088);
        q_edge.push_back(33);
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd99; op_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(seen, cyc);
        cyc = cyc + 5;
        pop_and_check(seen, cyc, 3'b000, 32'd123, 32'd456);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check_val("no_second_done", 64'(extra_done), 64'd0);
        check_val("idle_after_ignored_start", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
